// File: rtl/noc_target_responder.sv
// NoC target responder: accepts one request flit at a time from the router
// local port, performs a single-cycle access to local 256-bit word storage,
// and returns one response flit to the requester.
module noc_target_responder #(
  parameter int unsigned NODE_X    = 0,
  parameter int unsigned NODE_Y    = 0,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_LSB  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_src_x,
  input  logic [3:0]   req_src_y,
  input  logic         req_write,
  input  logic [63:0]  req_addr,
  input  logic [255:0] req_wdata,
  input  logic [7:0]   req_tag,
  input  logic [1:0]   req_qos,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [3:0]   rsp_dst_x,
  output logic [3:0]   rsp_dst_y,
  output logic         rsp_write_ack,
  output logic [255:0] rsp_rdata,
  output logic [7:0]   rsp_tag,
  output logic [1:0]   rsp_qos,
  output logic         rsp_error,
  output logic         busy,
  output logic [31:0]  req_count,
  output logic [31:0]  err_count
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [63:0] OFF_MASK = (64'd1 << ADDR_LSB) - 64'd1;

  // Elaboration-time sanity on parameters
  if (NODE_X > 15 || NODE_Y > 15) begin : g_bad_coord
    $error("noc_target_responder: node coordinates must fit in 4 bits");
  end
  if ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0 || ADDR_LSB == 0) begin : g_bad_geom
    $error("noc_target_responder: MEM_DEPTH must be a power of two, ADDR_LSB >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e state_q, state_d;

  logic [3:0]       src_x_q, src_y_q;
  logic             write_q, err_q;
  logic [IDX_W-1:0] idx_q;
  logic [255:0]     wdata_q, rdata_q;
  logic [7:0]       tag_q;
  logic [1:0]       qos_q;
  logic [31:0]      req_count_q, err_count_q;
  logic [255:0]     mem_q [MEM_DEPTH];

  logic [63:0] word_idx_c;
  logic        req_err_c;
  logic        accept_c;
  logic        do_write_c;

  // Request decode: word index and misalignment / range error
  always_comb begin
    word_idx_c = req_addr >> ADDR_LSB;
    req_err_c  = ((req_addr & OFF_MASK) != 64'd0) || (word_idx_c >= 64'(MEM_DEPTH));
    accept_c   = req_valid && (state_q == S_IDLE);
    do_write_c = (state_q == S_ACCESS) && write_q && !err_q;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      S_IDLE:   begin req_ready = 1'b1; busy = 1'b0; end
      S_ACCESS: ;
      S_RESP:   rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Request capture, read data register and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_x_q     <= '0;
      src_y_q     <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      tag_q       <= '0;
      qos_q       <= '0;
      req_count_q <= '0;
      err_count_q <= '0;
    end else begin
      if (accept_c) begin
        src_x_q <= req_src_x;
        src_y_q <= req_src_y;
        write_q <= req_write;
        err_q   <= req_err_c;
        idx_q   <= IDX_W'(word_idx_c);
        wdata_q <= req_wdata;
        tag_q   <= req_tag;
        qos_q   <= req_qos;
        if (req_count_q != 32'hFFFF_FFFF) req_count_q <= req_count_q + 32'd1;
        if (req_err_c && err_count_q != 32'hFFFF_FFFF) err_count_q <= err_count_q + 32'd1;
      end
      if (state_q == S_ACCESS) begin
        rdata_q <= (!write_q && !err_q) ? mem_q[idx_q] : '0;
      end
    end
  end

  // Local storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (do_write_c) mem_q[idx_q] <= wdata_q;
  end

  assign rsp_dst_x     = src_x_q;
  assign rsp_dst_y     = src_y_q;
  assign rsp_write_ack = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_tag       = tag_q;
  assign rsp_qos       = qos_q;
  assign rsp_error     = err_q;
  assign req_count     = req_count_q;
  assign err_count     = err_count_q;

endmodule
